// File: rtl/edt_tdr_access_sequencer.sv
// rtl/edt_tdr_access_sequencer.sv - IJTAG capture/shift/update sequencer for one EDT control TDR
// Optional write read-back verify pass: define EDT_TDR_SEQ_VERIFY_EN.
module edt_tdr_access_sequencer #(
    parameter int TDR_LEN = 2,
    parameter int CNT_W   = $clog2(TDR_LEN + 1)
) (
    input  logic               ijtag_tck,
    input  logic               ijtag_reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [TDR_LEN-1:0] req_wdata,
    output logic               resp_valid,
    output logic [TDR_LEN-1:0] resp_rdata,
    output logic               resp_mismatch,
    output logic               busy,
    output logic               ijtag_sel,
    output logic               ijtag_ce,
    output logic               ijtag_se,
    output logic               ijtag_ue,
    output logic               ijtag_si,
    input  logic               ijtag_so
);

`ifdef EDT_TDR_SEQ_VERIFY_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_CAPTURE, ST_SHIFT, ST_UPDATE, ST_DONE,
        ST_VCAPTURE, ST_VSHIFT, ST_VCOMPARE
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE, ST_CAPTURE, ST_SHIFT, ST_UPDATE, ST_DONE
    } state_t;
`endif

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TDR_LEN - 1);

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic               write_q;
    logic [TDR_LEN-1:0] data_q;
    logic [TDR_LEN-1:0] data_shr;
    logic [TDR_LEN-1:0] rdata_shr;

    // Captured bits enter at the MSB so that after TDR_LEN shifts bit i holds sample i.
    assign data_shr  = data_q >> 1;
    assign rdata_shr = TDR_LEN'({ijtag_so, resp_rdata} >> 1);

`ifdef EDT_TDR_SEQ_VERIFY_EN
    logic [TDR_LEN-1:0] wdata_q;
    logic [TDR_LEN-1:0] vcap_q;
    logic [TDR_LEN-1:0] vcap_shr;
    logic               mismatch_q;

    assign vcap_shr      = TDR_LEN'({ijtag_so, vcap_q} >> 1);
    assign resp_mismatch = mismatch_q;
`else
    assign resp_mismatch = 1'b0;
`endif

    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            state      <= ST_IDLE;
            count      <= '0;
            write_q    <= 1'b0;
            data_q     <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            busy       <= 1'b0;
            ijtag_sel  <= 1'b0;
            ijtag_ce   <= 1'b0;
            ijtag_se   <= 1'b0;
            ijtag_ue   <= 1'b0;
            ijtag_si   <= 1'b0;
`ifdef EDT_TDR_SEQ_VERIFY_EN
            wdata_q    <= '0;
            vcap_q     <= '0;
            mismatch_q <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        write_q   <= req_write;
                        data_q    <= req_wdata;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        ijtag_sel <= 1'b1;
                        ijtag_ce  <= 1'b1;
                        state     <= ST_CAPTURE;
`ifdef EDT_TDR_SEQ_VERIFY_EN
                        wdata_q    <= req_wdata;
                        mismatch_q <= 1'b0;
`endif
                    end
                end
                ST_CAPTURE: begin
                    ijtag_ce <= 1'b0;
                    ijtag_se <= 1'b1;
                    ijtag_si <= data_q[0];
                    count    <= '0;
                    state    <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    data_q     <= data_shr;
                    resp_rdata <= rdata_shr;
                    if (count == LAST) begin
                        ijtag_se <= 1'b0;
                        ijtag_si <= 1'b0;
                        if (write_q) begin
                            ijtag_ue <= 1'b1;
                            state    <= ST_UPDATE;
                        end else begin
                            ijtag_sel  <= 1'b0;
                            resp_valid <= 1'b1;
                            state      <= ST_DONE;
                        end
                    end else begin
                        count    <= count + 1'b1;
                        ijtag_si <= data_shr[0];
                    end
                end
                ST_UPDATE: begin
                    ijtag_ue <= 1'b0;
`ifdef EDT_TDR_SEQ_VERIFY_EN
                    // Re-arm the original write value and read the TDR back.
                    data_q   <= wdata_q;
                    ijtag_ce <= 1'b1;
                    state    <= ST_VCAPTURE;
`else
                    ijtag_sel  <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= ST_DONE;
`endif
                end
`ifdef EDT_TDR_SEQ_VERIFY_EN
                ST_VCAPTURE: begin
                    ijtag_ce <= 1'b0;
                    ijtag_se <= 1'b1;
                    ijtag_si <= data_q[0];
                    count    <= '0;
                    state    <= ST_VSHIFT;
                end
                ST_VSHIFT: begin
                    data_q <= data_shr;
                    vcap_q <= vcap_shr;
                    if (count == LAST) begin
                        ijtag_se <= 1'b0;
                        ijtag_si <= 1'b0;
                        state    <= ST_VCOMPARE;
                    end else begin
                        count    <= count + 1'b1;
                        ijtag_si <= data_shr[0];
                    end
                end
                // Compare in its own cycle so the last read-back bit is already registered.
                ST_VCOMPARE: begin
                    mismatch_q <= (vcap_q != wdata_q);
                    ijtag_sel  <= 1'b0;
                    resp_valid <= 1'b1;
                    state      <= ST_DONE;
                end
`endif
                ST_DONE: begin
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    ijtag_sel <= 1'b0;
                    ijtag_ce  <= 1'b0;
                    ijtag_se  <= 1'b0;
                    ijtag_ue  <= 1'b0;
                    ijtag_si  <= 1'b0;
                end
            endcase
        end
    end

endmodule
